// File: rtl/led_rgb_pwm_if.sv
// Control and pin bundle for led_rgb_pwm_driver: level codes and brightness in,
// grouped LED pins and the period marker out.
interface led_rgb_pwm_if #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned LED_W  = 4,
  parameter int unsigned CNT_W  = 8
);
  logic                      en;
  logic [2*NUM_CH-1:0]       level;
  logic [CNT_W-1:0]          bright;
  logic [LED_W*NUM_CH-1:0]   led_out;
  logic                      period_start;

  modport master (
    output en,
    output level,
    output bright,
    input  led_out,
    input  period_start
  );

  modport slave (
    input  en,
    input  level,
    input  bright,
    output led_out,
    output period_start
  );
endinterface

// File: rtl/led_rgb_pwm_driver.sv
// Multi-channel LED PWM driver: shared period counter, per-channel thresholds latched
// at period boundaries. Define LED_PWM_FADE_EN for one-LSB-per-period fading.
module led_rgb_pwm_driver #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned LED_W  = 4,
  parameter int unsigned CNT_W  = 8
) (
  input logic          clk,
  input logic          rst,
  led_rgb_pwm_if.slave bus
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] Three  = CNT_W'(3);

  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [NUM_CH-1:0][CNT_W-1:0]  thr_q, thr_d;
  logic [NUM_CH-1:0][CNT_W-1:0]  target;
  logic [LED_W*NUM_CH-1:0]       led_q, led_d;
  logic                          ps_q, ps_d;
  logic                          boundary;

  assign boundary = bus.en && (cnt_q == CntMax);

  always_comb begin
    target = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      unique case (bus.level[2*c +: 2])
        2'b00:   target[c] = '0;
        2'b01:   target[c] = bus.bright / Three;
        2'b10:   target[c] = bus.bright >> 1;
        2'b11:   target[c] = bus.bright;
        default: target[c] = '0;
      endcase
    end
  end

  always_comb begin
    cnt_d = bus.en ? cnt_q + 1'b1 : '0;
    ps_d  = boundary;
    thr_d = thr_q;
    led_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!bus.en) begin
`ifndef LED_PWM_FADE_EN
        thr_d[c] = target[c];
`endif
      end else if (boundary) begin
`ifdef LED_PWM_FADE_EN
        if (thr_q[c] < target[c]) begin
          thr_d[c] = thr_q[c] + 1'b1;
        end else if (thr_q[c] > target[c]) begin
          thr_d[c] = thr_q[c] - 1'b1;
        end
`else
        thr_d[c] = target[c];
`endif
      end
      // Compare uses the pre-edge count, so pins trail the counter by one cycle.
      if (bus.en && (cnt_q < thr_q[c])) begin
        led_d[LED_W*c +: LED_W] = {LED_W{1'b1}};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      thr_q <= '0;
      led_q <= '0;
      ps_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      thr_q <= thr_d;
      led_q <= led_d;
      ps_q  <= ps_d;
    end
  end

  assign bus.led_out      = led_q;
  assign bus.period_start = ps_q;

endmodule

// File: tb/tb_led_rgb_pwm_driver.sv
// Directed bench for led_rgb_pwm_driver: per-period lit-cycle counts per channel.
module tb_led_rgb_pwm_driver;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned LED_W  = 4;
  localparam int unsigned CNT_W  = 8;

  typedef struct {
    string      name;
    logic [5:0] level;
    logic [7:0] bright;
    int         e0;
    int         e1;
    int         e2;
  } vec_t;

  logic clk;
  logic rst;
  int   ntests;
  int   nfail;

  led_rgb_pwm_if #(.NUM_CH(NUM_CH), .LED_W(LED_W), .CNT_W(CNT_W)) dut_if ();

  led_rgb_pwm_driver #(.NUM_CH(NUM_CH), .LED_W(LED_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until period_start is seen; leaves us in the first cycle of the period.
  task automatic wait_ps(input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!dut_if.period_start && n < 600);
    check({name, " period_start seen"}, int'(dut_if.period_start), 1);
  endtask

  // Sample 256 cycles from the current one; ends in the cnt=255 cycle.
  task automatic measure(input string name, input int e0, input int e1, input int e2,
                         input int ps0);
    int lit [3];
    int bad;
    int ps_mid;
    int ps_first;
    lit = '{0, 0, 0};
    bad = 0;
    ps_mid = 0;
    ps_first = 0;
    for (int i = 0; i < 256; i++) begin
      if (i > 0) step();
      if (i == 0) ps_first = int'(dut_if.period_start);
      else if (dut_if.period_start) ps_mid++;
      for (int c = 0; c < 3; c++) begin
        if (dut_if.led_out[LED_W*c +: LED_W] == 4'hF) lit[c]++;
        else if (dut_if.led_out[LED_W*c +: LED_W] != 4'h0) bad++;
      end
    end
    check({name, " ch0 lit"}, lit[0], e0);
    check({name, " ch1 lit"}, lit[1], e1);
    check({name, " ch2 lit"}, lit[2], e2);
    check({name, " split pins"}, bad, 0);
    check({name, " period_start first"}, ps_first, ps0);
    check({name, " period_start mid"}, ps_mid, 0);
  endtask

  initial begin
    vec_t vecs [6];
    int   n;
    int   lit;
    int   last;
    int   bad;

    ntests = 0;
    nfail  = 0;
    rst = 1'b1;
    dut_if.en = 1'b0;
    dut_if.level = '0;
    dut_if.bright = '0;

    vecs[0] = '{"v_full",   6'b11_10_01, 8'd255,  85, 127, 255};
    vecs[1] = '{"v_off",    6'b00_00_00, 8'd255,   0,   0,   0};
    vecs[2] = '{"v_dim0",   6'b11_11_11, 8'd0,     0,   0,   0};
    vecs[3] = '{"v_b200",   6'b01_11_10, 8'd200, 100, 200,  66};
    vecs[4] = '{"v_b7",     6'b00_01_11, 8'd7,     7,   2,   0};
    vecs[5] = '{"v_b3",     6'b10_00_01, 8'd3,     1,   0,   1};

    repeat (3) step();
    check("reset led_out", int'(dut_if.led_out), 0);
    check("reset period_start", int'(dut_if.period_start), 0);
    check("reset cnt", int'(dut.cnt_q), 0);
    rst = 1'b0;

`ifdef LED_PWM_FADE_EN
    begin
      int up [5];
      int dn [4];
      up = '{1, 2, 3, 4, 4};
      dn = '{3, 2, 1, 0};
      dut_if.level = 6'b00_00_11;
      dut_if.bright = 8'd4;
      dut_if.en = 1'b1;
      for (int k = 0; k < 5; k++) begin
        wait_ps("fade up");
        measure("fade up", up[k], 0, 0, 1);
      end
      dut_if.level = 6'b00_00_00;
      for (int k = 0; k < 4; k++) begin
        wait_ps("fade down");
        measure("fade down", dn[k], 0, 0, 1);
      end
    end
`else
    dut_if.en = 1'b1;
    for (int v = 0; v < 6; v++) begin
      dut_if.level = vecs[v].level;
      dut_if.bright = vecs[v].bright;
      wait_ps(vecs[v].name);
      measure(vecs[v].name, vecs[v].e0, vecs[v].e1, vecs[v].e2, 1);
    end

    // Mid-period code change: current period keeps its latched threshold.
    dut_if.level = 6'b00_00_11;
    dut_if.bright = 8'd200;
    wait_ps("midchange");
    lit = 0;
    last = -1;
    for (int i = 0; i < 256; i++) begin
      if (i > 0) step();
      if (dut_if.led_out[3:0] == 4'hF) begin
        lit++;
        last = i;
      end
      if (i == 100) dut_if.level = 6'b00_00_00;
    end
    check("midchange ch0 lit", lit, 200);
    check("midchange ch0 last lit", last, 200);
    wait_ps("midchange next");
    measure("midchange next", 0, 0, 0, 1);

    // Reset pulse at cnt=50.
    dut_if.level = vecs[0].level;
    dut_if.bright = vecs[0].bright;
    wait_ps("rst pulse");
    repeat (50) step();
    rst = 1'b1;
    #1;
    check("rst async led_out", int'(dut_if.led_out), 0);
    check("rst async cnt", int'(dut.cnt_q), 0);
    step();
    rst = 1'b0;
    n = 0;
    lit = 0;
    do begin
      step();
      n++;
      if (!dut_if.period_start && dut_if.led_out != '0) lit++;
    end while (!dut_if.period_start && n < 600);
    check("post rst period length", n, 256);
    check("post rst dark cycles lit", lit, 0);
    measure("post rst duty", 85, 127, 255, 1);

    // en low for 300 cycles mid-period; new settings take effect on restart.
    repeat (80) step();
    dut_if.en = 1'b0;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (dut_if.led_out != '0 || dut_if.period_start) bad++;
      if (i == 10) begin
        dut_if.level = vecs[3].level;
        dut_if.bright = vecs[3].bright;
      end
    end
    check("en low outputs quiet", bad, 0);
    dut_if.en = 1'b1;
    measure("en restart", 100, 200, 66, 0);
    wait_ps("en restart next");
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
